// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road intersection controller:
// the phase encoding seen on the monitor port and the one-hot lamp patterns.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    PED_WALK  = 3'd6
  } phase_t;

  // Lamp patterns, {red, yellow, green}
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Phase duration timer: counts edges since the last clear and flags the
// terminal edge (count == limit-1). The limit is one bit wider than the
// counter so a duration of exactly 2^TIMER_W can be expressed without overflow.
module phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [TIMER_W:0] limit,
  output logic             done
);

  logic [TIMER_W-1:0] count_reg;

  // Count up every edge; a clear reloads to zero for the next phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Terminal compare done in the wider domain so limit = 2^TIMER_W is exact
  always_comb begin
    done = ({1'b0, count_reg} == (limit - 1'b1));
  end

endmodule

// File: rtl/traffic_intersection_controller.sv
// Two-road intersection controller: NS and EW heads cycle through green,
// yellow and all-red clearance, each phase held for its configured duration.
// Optional pedestrian walk phase after ALL_RED_B when macro TLC_PED_EN is
// defined; without it ped_req is ignored and walk stays low.
module traffic_intersection_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES   = 10,
  parameter int YELLOW_CYCLES  = 3,
  parameter int ALL_RED_CYCLES = 2,
  parameter int WALK_CYCLES    = 6,
  parameter int TIMER_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int LW = TIMER_W + 1;
  localparam logic [TIMER_W:0] GREEN_LIM  = LW'(GREEN_CYCLES);
  localparam logic [TIMER_W:0] YELLOW_LIM = LW'(YELLOW_CYCLES);
  localparam logic [TIMER_W:0] RED_LIM    = LW'(ALL_RED_CYCLES);
  localparam logic [TIMER_W:0] WALK_LIM   = LW'(WALK_CYCLES);

  phase_t           state_reg;
  phase_t           state_next;
  logic [TIMER_W:0] limit;
  logic             done;
  logic             timer_clr;
  logic             ped_go;

  // Duration of the phase currently being timed
  always_comb begin
    limit = RED_LIM;
    case (state_reg)
      NS_GREEN, EW_GREEN:   limit = GREEN_LIM;
      NS_YELLOW, EW_YELLOW: limit = YELLOW_LIM;
      ALL_RED_A, ALL_RED_B: limit = RED_LIM;
      PED_WALK:             limit = WALK_LIM;
      default:              limit = RED_LIM;
    endcase
  end

  phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .limit (limit),
    .done  (done)
  );

`ifdef TLC_PED_EN
  logic ped_pending_reg;

  // Latch requests until the walk that services them starts; a request on
  // the very edge that starts the walk is kept for the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pending_reg <= 1'b0;
    end else if (ped_req) begin
      ped_pending_reg <= 1'b1;
    end else if ((state_reg == ALL_RED_B) && done) begin
      ped_pending_reg <= 1'b0;
    end
  end

  assign ped_go = ped_pending_reg;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_go         = 1'b0;
`endif

  // State register; reset parks in ALL_RED_B so both roads start red
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ALL_RED_B;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state sequencing; an illegal encoding recovers to ALL_RED_B at once
  always_comb begin
    state_next = state_reg;
    timer_clr  = done;
    case (state_reg)
      NS_GREEN:  if (done) state_next = NS_YELLOW;
      NS_YELLOW: if (done) state_next = ALL_RED_A;
      ALL_RED_A: if (done) state_next = EW_GREEN;
      EW_GREEN:  if (done) state_next = EW_YELLOW;
      EW_YELLOW: if (done) state_next = ALL_RED_B;
      ALL_RED_B: if (done) state_next = ped_go ? PED_WALK : NS_GREEN;
      PED_WALK:  if (done) state_next = NS_GREEN;
      default: begin
        state_next = ALL_RED_B;
        timer_clr  = 1'b1;
      end
    endcase
  end

  // Moore decode of lamps, walk and monitor phase
  always_comb begin
    ns_light = RED;
    ew_light = RED;
    walk     = 1'b0;
    phase    = state_reg;
    case (state_reg)
      NS_GREEN:  ns_light = GREEN;
      NS_YELLOW: ns_light = YELLOW;
      EW_GREEN:  ew_light = GREEN;
      EW_YELLOW: ew_light = YELLOW;
`ifdef TLC_PED_EN
      PED_WALK:  walk     = 1'b1;
`endif
      default: begin
        ns_light = RED;
        ew_light = RED;
      end
    endcase
  end

endmodule
